// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between instruction fetch
// and data access. MEM has priority, but only for a bounded run of grants
// while a fetch is waiting. Each transfer is a req/ack handshake with a
// timeout, followed by a one-cycle turnaround state that carries the ack.
module mem_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch requester
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    output logic              stallreq_if_o,
    // data access requester
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    output logic              stallreq_mem_o,
    // external bus
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              bus_err_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_XFER  = 2'd1,
        MEM_XFER = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] tcnt;
    logic [SW-1:0] starve_cnt;
    logic          grant_mem, grant_if;
    logic          in_xfer;
    logic          xfer_abort;

    assign in_xfer = (state == IF_XFER) || (state == MEM_XFER);

    // bus_req_o is decoded from state so an async reset drops it at once
    assign bus_req_o      = in_xfer;
    assign stallreq_if_o  = if_req_i & ~if_ack_o;
    assign stallreq_mem_o = mem_req_i & ~mem_ack_o;

    // Next-state logic: grant decision in IDLE, ack/timeout in transfer
    always_comb begin
        state_n    = state;
        grant_mem  = 1'b0;
        grant_if   = 1'b0;
        xfer_abort = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req_i && (!if_req_i || starve_cnt < SW'(STARVE_LIMIT))) begin
                    grant_mem = 1'b1;
                    state_n   = MEM_XFER;
                end else if (if_req_i) begin
                    grant_if = 1'b1;
                    state_n  = IF_XFER;
                end
            end
            IF_XFER, MEM_XFER: begin
                // a late ack in the final cycle still counts as success
                if (bus_ack_i) begin
                    state_n = DONE;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    xfer_abort = 1'b1;
                    state_n    = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Transfer cycle counter, zero on every entry into a transfer state
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          tcnt <= '0;
        else if (in_xfer) tcnt <= tcnt + 1'b1;
        else              tcnt <= '0;
    end

    // Consecutive MEM grants taken while a fetch was waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_mem && if_req_i) begin
            if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
        end else if (grant_mem || grant_if) begin
            starve_cnt <= '0;
        end
    end

    // Latch the winning request onto the bus; held for the whole transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'b0000;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
        end else if (grant_mem) begin
            bus_we_o    <= mem_we_i;
            bus_sel_o   <= mem_sel_i;
            bus_addr_o  <= mem_addr_i;
            bus_wdata_o <= mem_wdata_i;
        end else if (grant_if) begin
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'b1111;
            bus_addr_o  <= if_addr_i;
            bus_wdata_o <= '0;
        end
    end

    // Completion pulses: high only in DONE, for the owner of the transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_ack_o  <= 1'b0;
            mem_ack_o <= 1'b0;
            bus_err_o <= 1'b0;
        end else begin
            if_ack_o  <= (state == IF_XFER)  && (state_n == DONE);
            mem_ack_o <= (state == MEM_XFER) && (state_n == DONE);
            bus_err_o <= xfer_abort;
        end
    end

    // Return data; zero on abort, otherwise held until the next completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_data_o   <= '0;
            mem_rdata_o <= '0;
        end else if (state_n == DONE) begin
            if (state == IF_XFER)  if_data_o   <= xfer_abort ? '0 : bus_rdata_i;
            if (state == MEM_XFER) mem_rdata_o <= xfer_abort ? '0 : bus_rdata_i;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed transactions push expected bus cycles
// and expected completions into queues; a bus responder and an ack monitor
// pop and compare independently of the stimulus.
module tb_mem_bus_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i, mem_req_i, mem_we_i, bus_ack_i;
    logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i, bus_rdata_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] if_data_o, mem_rdata_o, bus_addr_o, bus_wdata_o;
    logic        if_ack_o, mem_ack_o, stallreq_if_o, stallreq_mem_o;
    logic        bus_req_o, bus_we_o, bus_err_o;
    logic [3:0]  bus_sel_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;   // cycles after bus_req_o rises; -1 = never ack
        logic [31:0] rdata;
        int          len;     // expected bus_req_o high cycles
    } bus_exp_t;

    typedef struct {
        logic        is_mem;
        logic [31:0] data;
        logic        err;
    } ack_exp_t;

    bus_exp_t bus_q[$];
    ack_exp_t ack_q[$];

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
        .if_ack_o(if_ack_o), .stallreq_if_o(stallreq_if_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
        .mem_ack_o(mem_ack_o), .stallreq_mem_o(stallreq_mem_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
        .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_bus(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                           input logic [31:0] wdata, input int delay, input logic [31:0] rdata);
        bus_exp_t b;
        b.we = we; b.sel = sel; b.addr = addr; b.wdata = wdata;
        b.delay = delay; b.rdata = rdata;
        b.len = (delay < 0) ? TIMEOUT : delay + 1;
        bus_q.push_back(b);
    endtask

    task automatic exp_xfer(input logic is_mem, input logic we, input logic [3:0] sel,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int delay, input logic [31:0] rdata);
        ack_exp_t a;
        exp_bus(we, sel, addr, wdata, delay, rdata);
        a.is_mem = is_mem;
        a.data   = (delay < 0) ? 32'h0 : rdata;
        a.err    = (delay < 0);
        ack_q.push_back(a);
    endtask

    task automatic if_txn(input logic [31:0] addr);
        int n = 0;
        if_req_i  = 1'b1;
        if_addr_i = addr;
        do begin @(negedge clk); n++; end while (!if_ack_o && n < 200);
        if (!if_ack_o) chk("if_ack_timeout", 32'd0, 32'd1);
        if_req_i = 1'b0;
    endtask

    task automatic mem_txn(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                           input logic [31:0] wdata);
        int n = 0;
        mem_req_i   = 1'b1;
        mem_we_i    = we;
        mem_sel_i   = sel;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        do begin @(negedge clk); n++; end while (!mem_ack_o && n < 200);
        if (!mem_ack_o) chk("mem_ack_timeout", 32'd0, 32'd1);
        mem_req_i = 1'b0;
    endtask

    // Bus responder: pops one expected bus cycle per transfer, checks the
    // latched fields every cycle, acks after the scripted delay
    initial begin : responder
        bus_exp_t cur;
        bit active = 0;
        int cnt = 0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'hA5A5_A5A5;
        forever begin
            @(negedge clk);
            bus_ack_i   = 1'b0;
            bus_rdata_i = 32'hA5A5_A5A5;
            if (bus_req_o && !rst) begin
                if (!active) begin
                    active = 1;
                    cnt = 0;
                    if (bus_q.size() == 0) begin
                        chk("unexpected_bus_cycle", 32'd1, 32'd0);
                        cur.we = bus_we_o; cur.sel = bus_sel_o; cur.addr = bus_addr_o;
                        cur.wdata = bus_wdata_o; cur.delay = 0; cur.rdata = 0; cur.len = 1;
                    end else begin
                        cur = bus_q.pop_front();
                    end
                end else begin
                    cnt++;
                end
                chk("bus_we", {31'd0, bus_we_o}, {31'd0, cur.we});
                chk("bus_sel", {28'd0, bus_sel_o}, {28'd0, cur.sel});
                chk("bus_addr", bus_addr_o, cur.addr);
                chk("bus_wdata", bus_wdata_o, cur.wdata);
                if (cnt == cur.delay) begin
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = cur.rdata;
                end
            end else begin
                if (active && !rst) chk("bus_req_len", cnt + 1, cur.len);
                active = 0;
            end
        end
    end

    // Ack monitor: every completion pops one expected response
    initial begin : ack_mon
        ack_exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                chk("two_acks", {31'd0, if_ack_o & mem_ack_o}, 32'd0);
                chk("err_without_ack", {31'd0, bus_err_o & ~(if_ack_o | mem_ack_o)}, 32'd0);
                chk("stall_if", {31'd0, stallreq_if_o}, {31'd0, if_req_i & ~if_ack_o});
                chk("stall_mem", {31'd0, stallreq_mem_o}, {31'd0, mem_req_i & ~mem_ack_o});
                if (if_ack_o || mem_ack_o) begin
                    if (ack_q.size() == 0) begin
                        chk("unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        e = ack_q.pop_front();
                        chk("ack_owner_mem", {31'd0, mem_ack_o}, {31'd0, e.is_mem});
                        chk("ack_data", e.is_mem ? mem_rdata_o : if_data_o, e.data);
                        chk("ack_err", {31'd0, bus_err_o}, {31'd0, e.err});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst = 1'b1;
        if_req_i = 0; if_addr_i = 0;
        mem_req_i = 0; mem_we_i = 0; mem_sel_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
        repeat (2) @(negedge clk);
        chk("rst_bus_req", {31'd0, bus_req_o}, 32'd0);
        chk("rst_if_ack", {31'd0, if_ack_o}, 32'd0);
        chk("rst_mem_ack", {31'd0, mem_ack_o}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err_o}, 32'd0);
        chk("rst_bus_addr", bus_addr_o, 32'd0);
        chk("rst_bus_sel", {28'd0, bus_sel_o}, 32'd0);
        chk("rst_if_data", if_data_o, 32'd0);
        chk("rst_mem_rdata", mem_rdata_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single fetch, ack two cycles after bus_req_o
        exp_xfer(0, 0, 4'hF, 32'h0000_0100, 32'h0, 2, 32'h3402_0001);
        if_txn(32'h0000_0100);
        @(negedge clk);

        // simultaneous requests: MEM write first, then IF
        exp_xfer(1, 1, 4'b0011, 32'h80, 32'hDEAD_BEEF, 1, 32'h0BAD_F00D);
        exp_xfer(0, 0, 4'hF, 32'h200, 32'h0, 1, 32'h1111_2222);
        fork
            mem_txn(1, 4'b0011, 32'h80, 32'hDEAD_BEEF);
            if_txn(32'h200);
        join
        @(negedge clk);

        // starvation bound: M,M,M,M,I,M,M,M,M,I,M with immediate acks
        for (int k = 0; k < 11; k++) begin
            if (k == 4 || k == 9) exp_xfer(0, 0, 4'hF, 32'h300 + k * 4, 32'h0, 0, 32'h5000 + k);
            else                  exp_xfer(1, 0, 4'hF, 32'h400 + k * 4, 32'h0, 0, 32'h6000 + k);
        end
        fork
            begin
                for (int j = 0; j < 9; j++)
                    mem_txn(0, 4'hF, 32'h400 + ((j < 4) ? j : (j < 8) ? j + 1 : j + 2) * 4, 32'h0);
            end
            begin
                if_txn(32'h300 + 4 * 4);
                if_txn(32'h300 + 9 * 4);
            end
        join
        @(negedge clk);

        // timeout: no bus ack at all
        exp_xfer(1, 0, 4'hF, 32'h500, 32'h0, -1, 32'h0);
        mem_txn(0, 4'hF, 32'h500, 32'h0);
        @(negedge clk);

        // ack in the final allowed cycle wins over the timeout
        exp_xfer(1, 0, 4'hF, 32'h504, 32'h0, TIMEOUT - 1, 32'h1234_5678);
        mem_txn(0, 4'hF, 32'h504, 32'h0);
        @(negedge clk);

        // reset in the middle of a MEM transfer
        exp_bus(0, 4'hF, 32'h600, 32'h0, -1, 32'h0);
        mem_req_i = 1'b1; mem_we_i = 0; mem_sel_i = 4'hF; mem_addr_i = 32'h600; mem_wdata_i = 0;
        repeat (5) @(negedge clk);
        chk("pre_rst_bus_req", {31'd0, bus_req_o}, 32'd1);
        rst = 1'b1;
        mem_req_i = 1'b0;
        #1;
        chk("midrst_bus_req", {31'd0, bus_req_o}, 32'd0);
        chk("midrst_mem_ack", {31'd0, mem_ack_o}, 32'd0);
        chk("midrst_bus_err", {31'd0, bus_err_o}, 32'd0);
        chk("midrst_bus_addr", bus_addr_o, 32'd0);
        chk("midrst_mem_rdata", mem_rdata_o, 32'd0);
        if_req_i = 1'b1; if_addr_i = 32'h700;
        exp_xfer(0, 0, 4'hF, 32'h700, 32'h0, 1, 32'hCAFE_0001);
        repeat (2) @(negedge clk);
        chk("midrst_mem_ack_held", {31'd0, mem_ack_o}, 32'd0);
        rst = 1'b0;
        chk("post_rst_starve", {29'd0, dut.starve_cnt}, 32'd0);
        if_txn(32'h700);

        repeat (4) @(negedge clk);
        chk("bus_q_drained", bus_q.size(), 32'd0);
        chk("ack_q_drained", ack_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
